// File: rtl/jtdd_vtimer_pkg.sv
// Shared constants for the programmable video timer: register map and
// default geometry (384x272 total, 256x224 visible).
package jtdd_vtimer_pkg;

    localparam int REG_HEND     = 0;
    localparam int REG_HB_START = 1;
    localparam int REG_HB_END   = 2;
    localparam int REG_HS_START = 3;
    localparam int REG_HS_END   = 4;
    localparam int REG_VEND     = 5;
    localparam int REG_VB_START = 6;
    localparam int REG_VB_END   = 7;
    localparam int REG_VS_START = 8;
    localparam int REG_VS_END   = 9;
    localparam int REG_IRQ0     = 10;

    // number of shadowed geometry registers (indices 0..9)
    localparam int NGEO = 10;

    localparam int DEF_HW       = 9;
    localparam int DEF_VW       = 9;
    localparam int DEF_NIRQ     = 2;
    localparam int DEF_HEND     = 383;
    localparam int DEF_HB_START = 256;
    localparam int DEF_HB_END   = 0;
    localparam int DEF_HS_START = 296;
    localparam int DEF_HS_END   = 328;
    localparam int DEF_VEND     = 271;
    localparam int DEF_VB_START = 240;
    localparam int DEF_VB_END   = 16;
    localparam int DEF_VS_START = 250;
    localparam int DEF_VS_END   = 254;

endpackage

// File: rtl/jtdd_vtimer_irq.sv
// One raster interrupt channel: line compare at the start of each line,
// latched until acknowledged. A set in the same clk as an ack wins.
module jtdd_vtimer_irq #(
    parameter int VW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          hzero,
    input  logic [VW-1:0] vdump,
    input  logic [VW-1:0] line,
    input  logic          ack,
    output logic          irq
);

    // set/clear latch, set has priority over ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (pxl_cen && hzero && (vdump == line)) begin
            irq <= 1'b1;
        end else if (ack) begin
            irq <= 1'b0;
        end
    end

endmodule

// File: rtl/jtdd_vtimer_prog.sv
// Programmable video timing generator. Geometry registers are written into a
// pending copy and moved to the active copy at frame start, so a frame never
// sees a mix of old and new geometry. Strobes compare against the next
// counter value so their registered edges line up with hdump itself.
module jtdd_vtimer_prog
    import jtdd_vtimer_pkg::*;
#(
    parameter int HW       = DEF_HW,
    parameter int VW       = DEF_VW,
    parameter int NIRQ     = DEF_NIRQ,
    parameter int HEND     = DEF_HEND,
    parameter int HB_START = DEF_HB_START,
    parameter int HB_END   = DEF_HB_END,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_END   = DEF_HS_END,
    parameter int VEND     = DEF_VEND,
    parameter int VB_START = DEF_VB_START,
    parameter int VB_END   = DEF_VB_END,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_END   = DEF_VS_END
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pxl_cen,
    input  logic                             cfg_we,
    input  logic [3:0]                       cfg_addr,
    input  logic [((HW > VW) ? HW : VW)-1:0] cfg_din,
    input  logic [NIRQ-1:0]                  irq_ack,
    output logic [HW-1:0]                    hdump,
    output logic [VW-1:0]                    vdump,
    output logic [VW-1:0]                    vrender,
    output logic                             LHBL,
    output logic                             LVBL,
    output logic                             HS,
    output logic                             VS,
    output logic [NIRQ-1:0]                  irq,
    output logic                             frame
);

    localparam int DW = (HW > VW) ? HW : VW;

    localparam logic [NGEO-1:0][DW-1:0] GEO_DEF = {
        DW'(VS_END), DW'(VS_START), DW'(VB_END), DW'(VB_START), DW'(VEND),
        DW'(HS_END), DW'(HS_START), DW'(HB_END), DW'(HB_START), DW'(HEND)
    };

    logic [NGEO-1:0][DW-1:0] pend, pend_nx, act, act_nx;
    logic [NIRQ-1:0][VW-1:0] irq_line;

    logic [HW-1:0] a_hend, n_hb_start, n_hb_end, n_hs_start, n_hs_end;
    logic [VW-1:0] a_vend, n_vend, n_vb_start, n_vb_end, n_vs_start, n_vs_end;

    logic          h_wrap, v_wrap, frame_start;
    logic [HW-1:0] hdump_nx;
    logic [VW-1:0] vdump_nx, vrender_nx;
    logic          lhbl_nx, lvbl_nx, hs_nx, vs_nx;

    assign a_hend     = act[REG_HEND][HW-1:0];
    assign a_vend     = act[REG_VEND][VW-1:0];
    assign n_hb_start = act_nx[REG_HB_START][HW-1:0];
    assign n_hb_end   = act_nx[REG_HB_END][HW-1:0];
    assign n_hs_start = act_nx[REG_HS_START][HW-1:0];
    assign n_hs_end   = act_nx[REG_HS_END][HW-1:0];
    assign n_vend     = act_nx[REG_VEND][VW-1:0];
    assign n_vb_start = act_nx[REG_VB_START][VW-1:0];
    assign n_vb_end   = act_nx[REG_VB_END][VW-1:0];
    assign n_vs_start = act_nx[REG_VS_START][VW-1:0];
    assign n_vs_end   = act_nx[REG_VS_END][VW-1:0];

    // next counter/strobe values; a write in the reload clk joins the reload
    always_comb begin
        pend_nx = pend;
        if (cfg_we && (cfg_addr < 4'(NGEO))) begin
            pend_nx[cfg_addr] = cfg_din;
        end

        h_wrap      = (hdump == a_hend);
        v_wrap      = (vdump == a_vend);
        frame_start = pxl_cen && h_wrap && v_wrap;
        act_nx      = frame_start ? pend_nx : act;

        hdump_nx = h_wrap ? '0 : hdump + 1'b1;
        vdump_nx = vdump;
        if (h_wrap) begin
            vdump_nx = v_wrap ? '0 : vdump + 1'b1;
        end
        vrender_nx = (vdump_nx == n_vend) ? '0 : vdump_nx + 1'b1;

        // later assignment has priority: equal start/end leaves LHBL high
        lhbl_nx = LHBL;
        if (hdump_nx == n_hb_start) lhbl_nx = 1'b0;
        if (hdump_nx == n_hb_end)   lhbl_nx = 1'b1;

        lvbl_nx = LVBL;
        if (hdump_nx == n_hb_start) begin
            if (vdump_nx == n_vb_start) lvbl_nx = 1'b0;
            if (vdump_nx == n_vb_end)   lvbl_nx = 1'b1;
        end

        hs_nx = HS;
        if (hdump_nx == n_hs_end)   hs_nx = 1'b0;
        if (hdump_nx == n_hs_start) hs_nx = 1'b1;

        vs_nx = VS;
        if (hdump_nx == n_hs_start) begin
            if (vdump_nx == n_vs_end)   vs_nx = 1'b0;
            if (vdump_nx == n_vs_start) vs_nx = 1'b1;
        end
    end

    // registers: config writes land every clk, timing advances on pxl_cen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend     <= GEO_DEF;
            act      <= GEO_DEF;
            irq_line <= {NIRQ{VW'(VB_START)}};
            hdump    <= '0;
            vdump    <= '0;
            vrender  <= VW'(1);
            LHBL     <= 1'b0;
            LVBL     <= 1'b0;
            HS       <= 1'b0;
            VS       <= 1'b0;
            frame    <= 1'b0;
        end else begin
            pend <= pend_nx;
            act  <= act_nx;
            for (int i = 0; i < NIRQ; i++) begin
                if (cfg_we && (cfg_addr == 4'(REG_IRQ0 + i))) begin
                    irq_line[i] <= cfg_din[VW-1:0];
                end
            end
            if (pxl_cen) begin
                hdump   <= hdump_nx;
                vdump   <= vdump_nx;
                vrender <= vrender_nx;
                LHBL    <= lhbl_nx;
                LVBL    <= lvbl_nx;
                HS      <= hs_nx;
                VS      <= vs_nx;
                if (frame_start) frame <= ~frame;
            end
        end
    end

    for (genvar i = 0; i < NIRQ; i++) begin : g_irq
        jtdd_vtimer_irq #(.VW(VW)) u_irq (
            .clk     (clk),
            .rst_n   (rst_n),
            .pxl_cen (pxl_cen),
            .hzero   (hdump == '0),
            .vdump   (vdump),
            .line    (irq_line[i]),
            .ack     (irq_ack[i]),
            .irq     (irq[i])
        );
    end

endmodule
